// File: rtl/vend_pkg.sv
// Shared definitions for the vending result stream and the dispense controller FSM.
package vend_pkg;

  localparam int unsigned ORDER_W = 1;

  // Result encoding produced by the vending FSM (its out / out_vld pair)
  localparam logic VEND_NO_CHG = 1'b0;
  localparam logic VEND_CHG    = 1'b1;

  localparam int unsigned STATE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 6'b000001,
    S_MOTOR    = 6'b000010,
    S_WAIT_SNS = 6'b000100,
    S_EJECT    = 6'b001000,
    S_DONE     = 6'b010000,
    S_JAM      = 6'b100000
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_order_fifo.sv
// Synchronous DEPTH x ORDER_W order queue; pushes into a full queue and pops from an empty one are ignored.
module vend_order_fifo
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ORDER_W-1:0]     push_data,
  input  logic                   pop,
  output logic [ORDER_W-1:0]     head_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_c,
  output logic                   empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [ORDER_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Executes queued vend orders: motor, drop-sensor wait, optional change eject, done pulse.
// Flags queue overflow and drop-sensor jams as sticky errors.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MOTOR_CYC   = 8,
  parameter int unsigned EJECT_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  input  logic                   in_chg,
  input  logic                   drop_sns,
  input  logic                   clr_err,
  output logic                   motor_on,
  output logic                   eject_on,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   err_ovf,
  output logic                   err_jam
);

  localparam int unsigned CNT_W = $clog2(max3(MOTOR_CYC, EJECT_CYC, TIMEOUT_CYC) + 1);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               chg_q;
  logic               chg_d;
  logic               pop_c;
  logic               jam_evt_c;
  logic               ovf_evt_c;
  logic [ORDER_W-1:0] head_c;
  logic               full_c;
  logic               empty_c;

  vend_order_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_vld),
    .push_data (in_chg),
    .pop       (pop_c),
    .head_c    (head_c),
    .count     (pending),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  assign ovf_evt_c = in_vld && full_c;

  // Next-state, counter and queue-pop decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chg_d     = chg_q;
    pop_c     = 1'b0;
    jam_evt_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          chg_d   = head_c;
          cnt_d   = CNT_W'(MOTOR_CYC - 1);
          state_d = S_MOTOR;
        end
      end
      S_MOTOR: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(TIMEOUT_CYC - 1);
          state_d = S_WAIT_SNS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT_SNS: begin
        // Sensor beats the timeout when both land in the same cycle
        if (drop_sns) begin
          if (chg_q == VEND_CHG) begin
            cnt_d   = CNT_W'(EJECT_CYC - 1);
            state_d = S_EJECT;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == '0) begin
          jam_evt_c = 1'b1;
          state_d   = S_JAM;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EJECT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: state_d = S_IDLE;
      S_JAM: begin
        if (clr_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; outputs are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      chg_q    <= VEND_NO_CHG;
      motor_on <= 1'b0;
      eject_on <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err_ovf  <= 1'b0;
      err_jam  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
      motor_on <= (state_d == S_MOTOR);
      eject_on <= (state_d == S_EJECT);
      done     <= (state_d == S_DONE);
      busy     <= (state_d != S_IDLE);
      err_ovf  <= ovf_evt_c || (err_ovf && !clr_err);
      err_jam  <= jam_evt_c || (err_jam && !clr_err);
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench for vend_dispense_ctrl: expected change per order is queued at push and checked at done.
module tb_vend_dispense_ctrl;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned MOTOR_CYC   = 8;
  localparam int unsigned EJECT_CYC   = 4;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned PW          = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic          in_chg;
  logic          drop_sns;
  logic          clr_err;
  logic          motor_on;
  logic          eject_on;
  logic          done;
  logic          busy;
  logic [PW-1:0] pending;
  logic          err_ovf;
  logic          err_jam;

  int n_vec    = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  int sns_delay = 1;
  int mot_cyc  = 0;
  int ej_cyc   = 0;
  logic prev_motor = 1'b0;
  bit exp_q[$];

  vend_dispense_ctrl #(
    .DEPTH       (DEPTH),
    .MOTOR_CYC   (MOTOR_CYC),
    .EJECT_CYC   (EJECT_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_chg   (in_chg),
    .drop_sns (drop_sns),
    .clr_err  (clr_err),
    .motor_on (motor_on),
    .eject_on (eject_on),
    .done     (done),
    .busy     (busy),
    .pending  (pending),
    .err_ovf  (err_ovf),
    .err_jam  (err_jam)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drop sensor: pulses on the sns_delay-th cycle after the motor stops (0 = never)
  initial begin : sensor
    int wcnt;
    bit arm;
    drop_sns = 1'b0;
    wcnt = 0;
    arm = 1'b0;
    forever begin
      @(negedge clk);
      drop_sns = 1'b0;
      if (rst === 1'b1) begin
        arm = 1'b0;
      end else if (motor_on === 1'b1) begin
        arm = 1'b1;
        wcnt = 0;
      end else if (arm) begin
        wcnt++;
        if (sns_delay != 0 && wcnt == sns_delay) begin
          drop_sns = 1'b1;
          arm = 1'b0;
        end
      end
    end
  end

  // Scoreboard consumer: each done pops the oldest expected order
  initial begin : monitor
    bit exp_chg;
    forever begin
      @(negedge clk);
      if (motor_on === 1'b1 && prev_motor !== 1'b1) begin
        mot_cyc = 0;
        ej_cyc = 0;
      end
      if (motor_on === 1'b1) mot_cyc++;
      if (eject_on === 1'b1) ej_cyc++;
      prev_motor = motor_on;
      if (done === 1'b1) begin
        done_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got done=1 at %0t, want no outstanding order to complete", $time);
        end else begin
          exp_chg = exp_q.pop_front();
          n_vec++;
          if (ej_cyc !== (exp_chg ? int'(EJECT_CYC) : 0)) begin
            n_bad++;
            $display("FAIL order_eject: got %0d eject cycles, want %0d (chg=%0d)",
                     ej_cyc, exp_chg ? EJECT_CYC : 0, exp_chg);
          end
          if (mot_cyc !== int'(MOTOR_CYC)) begin
            n_bad++;
            $display("FAIL order_motor: got %0d motor cycles, want %0d", mot_cyc, MOTOR_CYC);
          end
        end
      end
    end
  end

  task automatic push_order(input bit chg, input bit accept);
    in_vld = 1'b1;
    in_chg = chg;
    if (accept) exp_q.push_back(chg);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic wait_motor(output bit ok);
    int n = 0;
    while (motor_on !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (motor_on === 1'b1);
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while (!(busy === 1'b0 && pending === '0) && n < 800) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0 && pending === '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_vld = 1'b0;
    in_chg = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({motor_on, eject_on, done, busy, err_ovf, err_jam} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, want 000000",
               {motor_on, eject_on, done, busy, err_ovf, err_jam});
    end
    n_vec++;
    if (pending !== '0) begin
      n_bad++;
      $display("FAIL reset_pending: got %0d, want 0", pending);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || pending !== '0) begin
      n_bad++;
      $display("FAIL reset_release: got busy=%b pending=%0d, want 0/0", busy, pending);
    end
  endtask

  task automatic test_single_order(input bit chg, input int k);
    int lat;
    int want;
    sns_delay = k;
    want = 1 + int'(MOTOR_CYC) + k + (chg ? int'(EJECT_CYC) : 0) + 1;
    push_order(chg, 1'b1);
    lat = 1;
    while (done !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat != want) begin
      n_bad++;
      $display("FAIL single_latency: got %0d cycles, want %0d (chg=%0d k=%0d)", lat, want, chg, k);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after_done: got done=%b busy=%b, want 0/0", done, busy);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL single_scoreboard: got %0d orders outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [5:0] pat;
    int base;
    bit ok;
    pat = 6'b101101;
    sns_delay = 1;
    base = done_cnt;
    push_order(1'b0, 1'b1);
    wait_motor(ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ovf_motor_start: got motor_on=%b, want 1 within bound", motor_on);
    end
    for (int i = 0; i < 6; i++) begin
      in_vld = 1'b1;
      in_chg = pat[i];
      if (i < int'(DEPTH)) exp_q.push_back(pat[i]);
      @(negedge clk);
    end
    in_vld = 1'b0;
    n_vec++;
    if (pending !== PW'(DEPTH)) begin
      n_bad++;
      $display("FAIL ovf_pending: got %0d, want %0d", pending, DEPTH);
    end
    n_vec++;
    if (err_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_flag: got err_ovf=%b, want 1", err_ovf);
    end
    wait_drain(ok);
    n_vec++;
    if (!ok || done_cnt - base != 1 + int'(DEPTH)) begin
      n_bad++;
      $display("FAIL ovf_done_count: got %0d done pulses (drained=%0d), want %0d",
               done_cnt - base, ok, 1 + DEPTH);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_vec++;
    if (err_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: got err_ovf=%b, want 0", err_ovf);
    end
  endtask

  task automatic test_jam();
    int base;
    int w;
    int n;
    bit ok;
    bit dropped;
    sns_delay = 0;
    base = done_cnt;
    push_order(1'b1, 1'b1);
    wait_motor(ok);
    n = 0;
    while (motor_on === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    push_order(1'b0, 1'b1);
    w = 1;
    while (err_jam !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (w != int'(TIMEOUT_CYC)) begin
      n_bad++;
      $display("FAIL jam_timeout: got %0d wait cycles, want %0d", w, TIMEOUT_CYC);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if ({motor_on, eject_on, busy, err_jam} !== 4'b0011 || pending !== PW'(1)) begin
      n_bad++;
      $display("FAIL jam_hold: got motor=%b eject=%b busy=%b err_jam=%b pending=%0d, want 0/0/1/1/1",
               motor_on, eject_on, busy, err_jam, pending);
    end
    dropped = exp_q.pop_front();
    sns_delay = 2;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_vec++;
    if (err_jam !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL jam_clear: got err_jam=%b busy=%b (abandoned chg=%0d), want 0/0", err_jam, busy, dropped);
    end
    wait_drain(ok);
    n_vec++;
    if (!ok || done_cnt - base != 1) begin
      n_bad++;
      $display("FAIL jam_resume: got %0d done pulses (drained=%0d), want 1", done_cnt - base, ok);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    bit ok;
    sns_delay = 1;
    base = done_cnt;
    push_order(1'b1, 1'b1);
    wait_motor(ok);
    push_order(1'b0, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_vec++;
    if (pending !== PW'(1) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: got pending=%0d busy=%b, want 1/0", pending, busy);
    end
    push_order(1'b1, 1'b1);
    n_vec++;
    if (pending !== PW'(1) || motor_on !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_push_pop: got pending=%0d motor_on=%b, want 1/1", pending, motor_on);
    end
    wait_drain(ok);
    n_vec++;
    if (!ok || done_cnt - base != 3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_done_count: got %0d done pulses, %0d outstanding, want 3/0",
               done_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int n;
    bit ok;
    sns_delay = 1;
    base = done_cnt;
    push_order(1'b1, 1'b1);
    wait_motor(ok);
    push_order(1'b0, 1'b1);
    push_order(1'b1, 1'b1);
    n = 0;
    while (eject_on !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (eject_on !== 1'b1 || pending !== PW'(2)) begin
      n_bad++;
      $display("FAIL rstmid_setup: got eject_on=%b pending=%0d, want 1/2", eject_on, pending);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_vec++;
    if ({eject_on, motor_on, busy, done} !== 4'b0 || pending !== '0) begin
      n_bad++;
      $display("FAIL rstmid_clear: got eject=%b motor=%b busy=%b done=%b pending=%0d, want all 0",
               eject_on, motor_on, busy, done, pending);
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (done_cnt != base || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got %0d done pulses busy=%b, want 0/0", done_cnt - base, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_vld = 1'b0;
    in_chg = 1'b0;
    clr_err = 1'b0;
    test_reset();
    test_single_order(1'b0, 3);
    test_single_order(1'b1, 1);
    test_overflow();
    test_jam();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
